lpm_hint_evaluator: RTL and testbench
=====================================

Name: lpm_hint_evaluator

Overview:
- Clocked parser for LPM hint strings of the form "NAME1=VAL1, NAME2=VAL2, ...".
- Given a hint string and a key name, it scans the hint one character per clock and returns the value bound to that key, or an empty string if the key is absent.
- FIFO and other LPM wrappers use it to resolve settings such as OVERFLOW_CHECKING and UNDERFLOW_CHECKING ("ON"/"OFF") from lpm_hint.

Parameters:
- HINT_CHARS, 64, hint buffer capacity in 8-bit characters.
- KEY_CHARS, 32, key buffer capacity in characters; also the maximum matchable name length.
- VAL_CHARS, 5, returned value width in characters.

Ports:
- clock  input  1  rising-edge clock.
- aclr  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; samples hint and key.
- hint  input  8*HINT_CHARS  hint string, Verilog packing (last character in bits [7:0]; unused leading bytes 0x00).
- key  input  8*KEY_CHARS  parameter name, same packing.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse when the result is valid.
- found  output  1  key present in hint (valid from done until next start).
- value  output  8*VAL_CHARS  matched value, same packing, zero-padded; all zeros when not found.

Behaviour:
- Reset: while aclr is high, and immediately on its rising edge, busy=0, done=0, found=0, value=0, and internal state returns to IDLE. Asserting aclr mid-scan aborts the scan; no done pulse is produced for it.
- IDLE, start=1 at a clock edge:
  - Capture hint and key into internal registers.
  - Set busy=1.
  - Clear the internal match state. found and value keep their old values until done.
- start while busy=1 is ignored.
- SCAN: one hint character per cycle, leftmost (MSB) byte first, for exactly HINT_CHARS cycles.
  - 0x00 and space (0x20) are ignored everywhere, in both hint and key.
  - Before '=': characters accumulate into the current token name. If the name exceeds KEY_CHARS characters, the token is marked unmatchable.
  - '=': ends the name. The name is compared, case-sensitive and exact, against the key with NULs and spaces stripped. The value phase begins.
  - After '=': characters shift into a VAL_CHARS-wide value register. If the value is longer than VAL_CHARS, the rightmost VAL_CHARS characters are kept.
  - ',' or end of string: closes the token. If the name matched, set the pending found=1 and latch the pending value (an empty value gives value=0 with found=1). Then clear the token state.
  - A token without '=' is ignored. A second '=' within a token is treated as a value character.
  - Duplicate keys: the last occurrence in the string wins.
  - An empty key (all NUL/space) never matches.
- DONE: on the cycle after the last character:
  - found and value update from the pending result.
  - done=1 for exactly one cycle; busy=0 in the same cycle.
  - Latency: done is high in the cycle that starts HINT_CHARS+1 clock edges after the edge that sampled start.
- A new start is accepted on the edge that ends the done cycle or any later edge.
- Outputs are registered and hold their values between operations.

Test Plan:
- hint="OVERFLOW_CHECKING=OFF, UNDERFLOW_CHECKING=ON", key="UNDERFLOW_CHECKING", start -> done after HINT_CHARS+1 cycles, found=1, value=40'h00_00_00_4F_4E ("ON").
- Same hint, key="OVERFLOW_CHECKING" -> found=1, value=40'h00_00_4F_46_46 ("OFF"). Key="LPM_MODE" -> found=0, value=0.
- hint all zeros, key="OVERFLOW_CHECKING" -> found=0, value=0. hint="A=1,A=2", key="A" -> found=1, value="2". hint="AB=X", key="A" -> found=0.
- hint="K=", key="K" -> found=1, value=0. hint="K=ABCDEFG", key="K" -> value="CDEFG".
- aclr pulsed 10 cycles after start -> busy=0, done never pulses, found=0, value=0. A subsequent start completes normally.
- Second start pulsed while busy -> ignored. Exactly one done per accepted start.

Source files
------------

// File: rtl/lpm_hint_evaluator.sv
// Scans an LPM hint string ("NAME=VAL, NAME=VAL") one character per clock.
// It returns the value bound to the requested key, or zero when the key is absent.
module lpm_hint_evaluator #(
   parameter int HINT_CHARS = 64,
   parameter int KEY_CHARS  = 32,
   parameter int VAL_CHARS  = 5
) (
   input  logic                    clock,
   input  logic                    aclr,
   input  logic                    start,
   input  logic [8*HINT_CHARS-1:0] hint,
   input  logic [8*KEY_CHARS-1:0]  key,
   output logic                    busy,
   output logic                    done,
   output logic                    found,
   output logic [8*VAL_CHARS-1:0]  value
);

   // state | meaning
   // IDLE  | waiting for start; outputs hold the last result
   // SCAN  | consuming one hint character per cycle, MSB byte first
   // FIN   | last character consumed; publish result and pulse done next edge

   localparam int HW = 8*HINT_CHARS;
   localparam int KW = 8*KEY_CHARS;
   localparam int VW = 8*VAL_CHARS;
   localparam int CW = $clog2(HINT_CHARS+1);
   localparam int LW = $clog2(KEY_CHARS+1);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_FIN} state_t;

   state_t          state;
   logic [HW-1:0]   hint_sr;
   logic [KW-1:0]   key_sq_r;
   logic [CW-1:0]   cnt;
   logic [KW-1:0]   name_r;
   logic [LW-1:0]   name_len;
   logic            name_ovf;
   logic            in_val;
   logic            tok_match;
   logic [VW-1:0]   val_r;
   logic            pend_found;
   logic [VW-1:0]   pend_val;

   logic [KW-1:0]   key_sq;
   logic [7:0]      kch;
   logic [7:0]      ch;
   logic            skip;
   logic            close_tok;
   logic [KW-1:0]   n_name;
   logic [LW-1:0]   n_len;
   logic            n_ovf;
   logic            n_in_val;
   logic            n_match;
   logic [VW-1:0]   n_val;
   logic            n_pfound;
   logic [VW-1:0]   n_pval;

   // Key with NULs and spaces squeezed out, right-aligned and zero-filled,
   // so it can be compared directly against the accumulated token name.
   always_comb begin
      key_sq = '0;
      kch    = 8'h00;
      for (int i = KEY_CHARS-1; i >= 0; i--) begin
         kch = key[8*i +: 8];
         if (kch != 8'h00 && kch != 8'h20)
            key_sq = {key_sq[KW-9:0], kch};
      end
   end

   always_comb begin
      ch        = hint_sr[HW-1 -: 8];
      skip      = (ch == 8'h00) || (ch == 8'h20);
      close_tok = (cnt == CW'(1));
      n_name    = name_r;
      n_len     = name_len;
      n_ovf     = name_ovf;
      n_in_val  = in_val;
      n_match   = tok_match;
      n_val     = val_r;
      n_pfound  = pend_found;
      n_pval    = pend_val;

      if (!skip) begin
         if (ch == 8'h2C) begin
            close_tok = 1'b1;
         end else if (ch == 8'h3D && !in_val) begin
            n_in_val = 1'b1;
            n_match  = !name_ovf && (name_r == key_sq_r) && (key_sq_r != '0);
         end else if (in_val) begin
            n_val = {val_r[VW-9:0], ch};
         end else if (name_len == LW'(KEY_CHARS)) begin
            n_ovf = 1'b1;
         end else begin
            n_name = {name_r[KW-9:0], ch};
            n_len  = name_len + LW'(1);
         end
      end

      // The final character closes the open token as if a comma followed it.
      if (close_tok) begin
         if (n_in_val && n_match) begin
            n_pfound = 1'b1;
            n_pval   = n_val;
         end
         n_name   = '0;
         n_len    = '0;
         n_ovf    = 1'b0;
         n_in_val = 1'b0;
         n_match  = 1'b0;
         n_val    = '0;
      end
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         state      <= ST_IDLE;
         hint_sr    <= '0;
         key_sq_r   <= '0;
         cnt        <= '0;
         name_r     <= '0;
         name_len   <= '0;
         name_ovf   <= 1'b0;
         in_val     <= 1'b0;
         tok_match  <= 1'b0;
         val_r      <= '0;
         pend_found <= 1'b0;
         pend_val   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         found      <= 1'b0;
         value      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  hint_sr    <= hint;
                  key_sq_r   <= key_sq;
                  cnt        <= CW'(HINT_CHARS);
                  name_r     <= '0;
                  name_len   <= '0;
                  name_ovf   <= 1'b0;
                  in_val     <= 1'b0;
                  tok_match  <= 1'b0;
                  val_r      <= '0;
                  pend_found <= 1'b0;
                  pend_val   <= '0;
                  busy       <= 1'b1;
                  state      <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               hint_sr    <= hint_sr << 8;
               cnt        <= cnt - CW'(1);
               name_r     <= n_name;
               name_len   <= n_len;
               name_ovf   <= n_ovf;
               in_val     <= n_in_val;
               tok_match  <= n_match;
               val_r      <= n_val;
               pend_found <= n_pfound;
               pend_val   <= n_pval;
               if (cnt == CW'(1))
                  state <= ST_FIN;
            end
            ST_FIN: begin
               found <= pend_found;
               value <= pend_val;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lpm_hint_evaluator.sv
// Directed bench for lpm_hint_evaluator: hint lookups, latency, abort and busy-start handling.
module tb_lpm_hint_evaluator;

   localparam int HINT_CHARS = 64;
   localparam int KEY_CHARS  = 32;
   localparam int VAL_CHARS  = 5;
   localparam int HW = 8*HINT_CHARS;
   localparam int KW = 8*KEY_CHARS;
   localparam int VW = 8*VAL_CHARS;

   logic          clock;
   logic          aclr;
   logic          start;
   logic [HW-1:0] hint_in;
   logic [KW-1:0] key;
   logic          busy;
   logic          done;
   logic          found;
   logic [VW-1:0] value;

   int checks;
   int failures;

   lpm_hint_evaluator #(
      .HINT_CHARS (HINT_CHARS),
      .KEY_CHARS  (KEY_CHARS),
      .VAL_CHARS  (VAL_CHARS)
   ) dut (
      .clock (clock),
      .aclr  (aclr),
      .start (start),
      .hint  (hint_in),
      .key   (key),
      .busy  (busy),
      .done  (done),
      .found (found),
      .value (value)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic run_case(input string tag, input logic [HW-1:0] h, input logic [KW-1:0] k,
                           input logic ef, input logic [VW-1:0] ev);
      int n;
      @(negedge clock);
      hint_in = h;
      key     = k;
      start   = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      chk({tag, ".busy"}, 64'(busy), 64'd1);
      n = 0;
      while (!done && n < 200) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk({tag, ".latency"}, 64'(n), 64'(HINT_CHARS+1));
      chk({tag, ".found"}, 64'(found), 64'(ef));
      chk({tag, ".value"}, 64'(value), 64'(ev));
      chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
      @(posedge clock);
      #1;
      chk({tag, ".done_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int dones;
      int first_n;
      checks   = 0;
      failures = 0;
      aclr     = 1'b1;
      start    = 1'b0;
      hint_in  = '0;
      key      = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst.busy",  64'(busy),  64'd0);
      chk("rst.done",  64'(done),  64'd0);
      chk("rst.found", 64'(found), 64'd0);
      chk("rst.value", 64'(value), 64'd0);
      @(negedge clock);
      aclr = 1'b0;

      run_case("unf", HW'("OVERFLOW_CHECKING=OFF, UNDERFLOW_CHECKING=ON"), KW'("UNDERFLOW_CHECKING"), 1'b1, 40'h00_00_00_4F_4E);
      run_case("ovf", HW'("OVERFLOW_CHECKING=OFF, UNDERFLOW_CHECKING=ON"), KW'("OVERFLOW_CHECKING"), 1'b1, 40'h00_00_4F_46_46);
      run_case("absent", HW'("OVERFLOW_CHECKING=OFF, UNDERFLOW_CHECKING=ON"), KW'("LPM_MODE"), 1'b0, 40'h0);
      run_case("zero_hint", HW'(0), KW'("OVERFLOW_CHECKING"), 1'b0, 40'h0);
      run_case("dup", HW'("A=1,A=2"), KW'("A"), 1'b1, 40'h32);
      run_case("prefix", HW'("AB=X"), KW'("A"), 1'b0, 40'h0);
      run_case("empty_val", HW'("K="), KW'("K"), 1'b1, 40'h0);
      run_case("long_val", HW'("K=ABCDEFG"), KW'("K"), 1'b1, 40'h43_44_45_46_47);
      run_case("spaces", HW'("A = 1"), KW'(" A "), 1'b1, 40'h31);
      run_case("second_eq", HW'("K=A=B"), KW'("K"), 1'b1, 40'h41_3D_42);
      run_case("no_eq", HW'("K, J=7"), KW'("K"), 1'b0, 40'h0);
      run_case("empty_key", HW'("=5, X=1"), KW'(0), 1'b0, 40'h0);
      run_case("pre_abort", HW'("K=9"), KW'("K"), 1'b1, 40'h39);

      // Abort mid-scan: outputs clear and no done is produced for the aborted scan.
      @(negedge clock);
      hint_in = HW'("K=8");
      key     = KW'("K");
      start   = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      aclr = 1'b1;
      #1;
      chk("abort.busy",  64'(busy),  64'd0);
      chk("abort.found", 64'(found), 64'd0);
      chk("abort.value", 64'(value), 64'd0);
      @(negedge clock);
      aclr  = 1'b0;
      dones = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clock);
         #1;
         if (done) dones++;
      end
      chk("abort.no_done", 64'(dones), 64'd0);
      run_case("post_abort", HW'("K=8"), KW'("K"), 1'b1, 40'h38);

      // A start raised while busy is ignored; only the original request completes.
      @(negedge clock);
      hint_in = HW'("P=1, Q=2");
      key     = KW'("P");
      start   = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      @(negedge clock);
      key   = KW'("Q");
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      dones   = 0;
      first_n = 0;
      for (int n = 6; n < 160; n++) begin
         @(posedge clock);
         #1;
         if (done) begin
            dones++;
            if (first_n == 0) begin
               first_n = n;
               chk("busy_start.found", 64'(found), 64'd1);
               chk("busy_start.value", 64'(value), 64'h31);
            end
         end
      end
      chk("busy_start.latency", 64'(first_n), 64'(HINT_CHARS+1));
      chk("busy_start.done_count", 64'(dones), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
